// File: rtl/sdram_cmd_sequencer_pkg.sv
// Shared SDRAM command encodings, default timings and the sequencer state type.
package sdram_cmd_sequencer_pkg;

    // {RAS, CAS, WE} as driven onto the command pins
    typedef enum logic [2:0] {
        CmdMrs   = 3'b000,
        CmdAr    = 3'b001,
        CmdPre   = 3'b010,
        CmdAct   = 3'b011,
        CmdWrite = 3'b100,
        CmdRead  = 3'b101,
        CmdTerm  = 3'b110,
        CmdNop   = 3'b111
    } sd_cmd_e;

    localparam int unsigned DefInitDelay       = 10000;
    localparam int unsigned DefRefreshInterval = 780;
    localparam int unsigned DefTRp             = 2;
    localparam int unsigned DefTRfc            = 7;
    localparam int unsigned DefTMrd            = 2;
    localparam logic [11:0] DefModeWord        = 12'h037;

    // A10 high selects all banks for PRE
    localparam logic [11:0] AddrAllBanks = 12'h400;

    typedef enum logic [3:0] {
        StInitWait,
        StInitPre,
        StInitAr1,
        StInitAr2,
        StInitMrs,
        StRun,
        StRefWait,
        StRefPre,
        StRefAr
    } seq_state_e;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter with a single-entry request flag and sticky overrun.
module sdram_refresh_timer
    import sdram_cmd_sequencer_pkg::*;
#(
    parameter int unsigned REFRESH_INTERVAL = DefRefreshInterval
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic pending,
    output logic overrun
);

    localparam int unsigned CntW = cnt_width(REFRESH_INTERVAL - 1);
    localparam logic [CntW-1:0] Reload = CntW'(REFRESH_INTERVAL - 1);

    logic            running_q, running_d;
    logic [CntW-1:0] count_q, count_d;
    logic            pending_q, pending_d;
    logic            overrun_q, overrun_d;
    logic            expire;

    always_comb begin
        expire    = running_q && (count_q == '0);
        running_d = running_q;
        count_d   = count_q;
        pending_d = pending_q;
        overrun_d = overrun_q;

        if (start) begin
            running_d = 1'b1;
            count_d   = Reload;
        end else if (running_q) begin
            count_d = expire ? Reload : count_q - CntW'(1);
        end

        // An expiry coinciding with clear is a fresh request, not an overrun
        if (expire) begin
            if (pending_q && !clear) begin
                overrun_d = 1'b1;
            end
            pending_d = 1'b1;
        end else if (clear) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running_q <= 1'b0;
            count_q   <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            running_q <= running_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/sdram_cmd_sequencer.sv
// SDRAM power-up init and auto-refresh sequencer; passes engine commands through when idle.
module sdram_cmd_sequencer
    import sdram_cmd_sequencer_pkg::*;
#(
    parameter int unsigned INIT_DELAY       = DefInitDelay,
    parameter int unsigned REFRESH_INTERVAL = DefRefreshInterval,
    parameter int unsigned T_RP             = DefTRp,
    parameter int unsigned T_RFC            = DefTRfc,
    parameter int unsigned T_MRD            = DefTMrd,
    parameter logic [11:0] MODE_WORD        = DefModeWord
) (
    input  logic        clk,
    input  logic        rst,
    output logic        sd_cke,
    output logic [2:0]  sd_command,
    output logic [11:0] sd_address,
    output logic [1:0]  sd_bank,
    output logic        ready,
    output logic        auto_refresh,
    output logic        refresh_overrun,
    input  logic        read_idle,
    input  logic [2:0]  read_command,
    input  logic [11:0] read_address,
    input  logic [1:0]  read_bank,
    input  logic        write_idle,
    input  logic [2:0]  write_command,
    input  logic [11:0] write_address,
    input  logic [1:0]  write_bank
);

    localparam int unsigned DelayW =
        cnt_width(max2(max2(INIT_DELAY, T_RFC), max2(T_RP, T_MRD)));

    seq_state_e        state_q, state_d;
    logic [DelayW-1:0] delay_q, delay_d;
    sd_cmd_e           cmd_q, cmd_d;
    logic [11:0]       addr_q, addr_d;
    logic [1:0]        bank_q, bank_d;
    logic              cke_q, cke_d;
    logic              ready_q, ready_d;
    logic              auto_ref_q, auto_ref_d;
    logic              timer_start, timer_clear;
    logic              pending;

    sdram_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (timer_start),
        .clear  (timer_clear),
        .pending(pending),
        .overrun(refresh_overrun)
    );

    // Each state acts only once its delay has drained; the state names the last command issued
    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        cmd_d       = CmdNop;
        addr_d      = '0;
        bank_d      = '0;
        cke_d       = 1'b1;
        ready_d     = ready_q;
        auto_ref_d  = auto_ref_q;
        timer_start = 1'b0;
        timer_clear = 1'b0;

        if (delay_q != '0) begin
            delay_d = delay_q - DelayW'(1);
        end else begin
            unique case (state_q)
                StInitWait: begin
                    cmd_d   = CmdPre;
                    addr_d  = AddrAllBanks;
                    delay_d = DelayW'(T_RP);
                    state_d = StInitPre;
                end
                StInitPre: begin
                    cmd_d   = CmdAr;
                    delay_d = DelayW'(T_RFC);
                    state_d = StInitAr1;
                end
                StInitAr1: begin
                    cmd_d   = CmdAr;
                    delay_d = DelayW'(T_RFC);
                    state_d = StInitAr2;
                end
                StInitAr2: begin
                    cmd_d   = CmdMrs;
                    addr_d  = MODE_WORD;
                    delay_d = DelayW'(T_MRD);
                    state_d = StInitMrs;
                end
                StInitMrs: begin
                    ready_d     = 1'b1;
                    auto_ref_d  = 1'b0;
                    timer_start = 1'b1;
                    state_d     = StRun;
                end
                StRun: begin
                    if (pending) begin
                        auto_ref_d = 1'b1;
                        state_d    = StRefWait;
                    end
                end
                StRefWait: begin
                    if (read_idle && write_idle) begin
                        cmd_d   = CmdPre;
                        addr_d  = AddrAllBanks;
                        delay_d = DelayW'(T_RP);
                        state_d = StRefPre;
                    end
                end
                StRefPre: begin
                    cmd_d       = CmdAr;
                    delay_d     = DelayW'(T_RFC);
                    timer_clear = 1'b1;
                    state_d     = StRefAr;
                end
                StRefAr: begin
                    auto_ref_d = 1'b0;
                    state_d    = StRun;
                end
                default: state_d = StInitWait;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StInitWait;
            delay_q    <= DelayW'(INIT_DELAY);
            cmd_q      <= CmdNop;
            addr_q     <= '0;
            bank_q     <= '0;
            cke_q      <= 1'b0;
            ready_q    <= 1'b0;
            auto_ref_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            bank_q     <= bank_d;
            cke_q      <= cke_d;
            ready_q    <= ready_d;
            auto_ref_q <= auto_ref_d;
        end
    end

    // Engines reach the pins combinationally only while the sequencer is not using the bus
    always_comb begin
        sd_command = cmd_q;
        sd_address = addr_q;
        sd_bank    = bank_q;
        if (state_q == StRun || state_q == StRefWait) begin
            if (!read_idle) begin
                sd_command = read_command;
                sd_address = read_address;
                sd_bank    = read_bank;
            end else if (!write_idle) begin
                sd_command = write_command;
                sd_address = write_address;
                sd_bank    = write_bank;
            end else begin
                sd_command = CmdNop;
                sd_address = '0;
                sd_bank    = '0;
            end
        end
    end

    assign sd_cke       = cke_q;
    assign ready        = ready_q;
    assign auto_refresh = auto_ref_q;

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Directed bench for sdram_cmd_sequencer with a schedule-based reference model.
module tb_sdram_cmd_sequencer;

    localparam int unsigned ID   = 20;
    localparam int unsigned RI   = 50;
    localparam int unsigned TRP  = 2;
    localparam int unsigned TRFC = 7;
    localparam int unsigned TMRD = 2;
    localparam logic [11:0] MW   = 12'h037;

    localparam logic [2:0] NOP = 3'b111;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] WRC = 3'b100;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] ARC = 3'b001;
    localparam logic [2:0] MRS = 3'b000;

    // Absolute init schedule, cycles after reset release
    localparam int PreT = ID + 1;
    localparam int Ar1T = PreT + TRP + 1;
    localparam int Ar2T = Ar1T + TRFC + 1;
    localparam int MrsT = Ar2T + TRFC + 1;
    localparam int RdyT = MrsT + TMRD + 1;

    localparam int PhInit = 0;
    localparam int PhRun  = 1;
    localparam int PhWait = 2;
    localparam int PhRef  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        sd_cke, ready, auto_refresh, refresh_overrun;
    logic [2:0]  sd_command;
    logic [11:0] sd_address;
    logic [1:0]  sd_bank;
    logic        read_idle, write_idle;
    logic [2:0]  read_command, write_command;
    logic [11:0] read_address, write_address;
    logic [1:0]  read_bank, write_bank;

    int vectors = 0;
    int miscompares = 0;
    int seg = 0;

    sdram_cmd_sequencer #(
        .INIT_DELAY      (ID),
        .REFRESH_INTERVAL(RI),
        .T_RP            (TRP),
        .T_RFC           (TRFC),
        .T_MRD           (TMRD),
        .MODE_WORD       (MW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sd_cke         (sd_cke),
        .sd_command     (sd_command),
        .sd_address     (sd_address),
        .sd_bank        (sd_bank),
        .ready          (ready),
        .auto_refresh   (auto_refresh),
        .refresh_overrun(refresh_overrun),
        .read_idle      (read_idle),
        .read_command   (read_command),
        .read_address   (read_address),
        .read_bank      (read_bank),
        .write_idle     (write_idle),
        .write_command  (write_command),
        .write_address  (write_address),
        .write_bank     (write_bank)
    );

    initial forever #5 clk = ~clk;

    // Reference model state, valid for the cycle following each rising edge
    bit          m_valid = 1'b0;
    bit          m_rst, m_cke, m_ready, m_ar, m_ovr, m_pend;
    int          m_t = 0;
    int          m_phase, m_run_t, m_ref_ar_t, m_ref_end_t;
    logic [2:0]  m_cmd;
    logic [11:0] m_addr;
    logic [1:0]  m_bank;

    initial begin
        bit ri, wi, exp_now, clr;
        forever begin
            @(posedge clk);
            ri = read_idle;
            wi = write_idle;
            m_valid = 1'b1;
            m_cmd = NOP;
            m_addr = '0;
            m_bank = '0;
            if (rst) begin
                m_rst = 1'b1; m_t = 0; m_cke = 1'b0; m_ready = 1'b0; m_ar = 1'b1;
                m_ovr = 1'b0; m_pend = 1'b0; m_phase = PhInit; m_run_t = -1;
            end else begin
                m_rst = 1'b0;
                m_t++;
                m_cke = 1'b1;
                clr = 1'b0;
                exp_now = (m_run_t >= 0) && (m_t > m_run_t) && (((m_t - m_run_t) % RI) == 0);
                case (m_phase)
                    PhInit: begin
                        if (m_t == PreT) begin
                            m_cmd = PRE; m_addr = 12'h400;
                        end else if (m_t == Ar1T || m_t == Ar2T) begin
                            m_cmd = ARC;
                        end else if (m_t == MrsT) begin
                            m_cmd = MRS; m_addr = MW;
                        end else if (m_t == RdyT) begin
                            m_ready = 1'b1; m_ar = 1'b0; m_phase = PhRun; m_run_t = m_t;
                        end
                    end
                    PhRun: begin
                        if (m_pend) begin
                            m_ar = 1'b1; m_phase = PhWait;
                        end
                    end
                    PhWait: begin
                        if (ri && wi) begin
                            m_cmd = PRE; m_addr = 12'h400;
                            m_ref_ar_t  = m_t + TRP + 1;
                            m_ref_end_t = m_ref_ar_t + TRFC + 1;
                            m_phase = PhRef;
                        end
                    end
                    default: begin
                        if (m_t == m_ref_ar_t) begin
                            m_cmd = ARC; clr = 1'b1;
                        end else if (m_t == m_ref_end_t) begin
                            m_ar = 1'b0; m_phase = PhRun;
                        end
                    end
                endcase
                if (exp_now) begin
                    if (m_pend && !clr) m_ovr = 1'b1;
                    m_pend = 1'b1;
                end else if (clr) begin
                    m_pend = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s seg=%0d t=%0d: got %h, expected %h", name, seg, m_t, got, exp);
        end
    endtask

    // Compare process: model every cycle plus hand-computed anchors
    initial begin
        logic [2:0]  e_cmd;
        logic [11:0] e_addr;
        logic [1:0]  e_bank;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                e_cmd = m_cmd; e_addr = m_addr; e_bank = m_bank;
                if (m_phase == PhRun || m_phase == PhWait) begin
                    if (!read_idle) begin
                        e_cmd = read_command; e_addr = read_address; e_bank = read_bank;
                    end else if (!write_idle) begin
                        e_cmd = write_command; e_addr = write_address; e_bank = write_bank;
                    end else begin
                        e_cmd = NOP; e_addr = '0; e_bank = '0;
                    end
                end
                check("sd_command", 12'(sd_command), 12'(e_cmd));
                check("sd_address", sd_address, e_addr);
                check("sd_bank", 12'(sd_bank), 12'(e_bank));
                check("sd_cke", 12'(sd_cke), 12'(m_cke));
                check("ready", 12'(ready), 12'(m_ready));
                check("auto_refresh", 12'(auto_refresh), 12'(m_ar));
                check("refresh_overrun", 12'(refresh_overrun), 12'(m_ovr));

                if (m_rst) begin
                    check("lit_rst_cke", 12'(sd_cke), 12'd0);
                    check("lit_rst_ready", 12'(ready), 12'd0);
                    check("lit_rst_ar", 12'(auto_refresh), 12'd1);
                    check("lit_rst_ovr", 12'(refresh_overrun), 12'd0);
                    check("lit_rst_cmd", 12'(sd_command), 12'(NOP));
                end else if (seg == 0) begin
                    case (m_t)
                        20: check("lit_nop20", 12'(sd_command), 12'(NOP));
                        21: begin
                            check("lit_pre21", 12'(sd_command), 12'(PRE));
                            check("lit_pre21_a10", sd_address, 12'h400);
                        end
                        24: check("lit_ar24", 12'(sd_command), 12'(ARC));
                        32: check("lit_ar32", 12'(sd_command), 12'(ARC));
                        40: begin
                            check("lit_mrs40", 12'(sd_command), 12'(MRS));
                            check("lit_mrs40_addr", sd_address, 12'h037);
                            check("lit_mrs40_bank", 12'(sd_bank), 12'd0);
                        end
                        42: check("lit_ready42", 12'(ready), 12'd0);
                        43: begin
                            check("lit_ready43", 12'(ready), 12'd1);
                            check("lit_ar43", 12'(auto_refresh), 12'd0);
                        end
                        55: check("lit_prio55", 12'(sd_command), 12'(ACT));
                        93: check("lit_ar93", 12'(auto_refresh), 12'd0);
                        94: check("lit_ar94", 12'(auto_refresh), 12'd1);
                        95: check("lit_pre95", 12'(sd_command), 12'(PRE));
                        98: check("lit_ar98", 12'(sd_command), 12'(ARC));
                        105: check("lit_ar105", 12'(auto_refresh), 12'd1);
                        106: check("lit_ar106", 12'(auto_refresh), 12'd0);
                        174: check("lit_busy_pre174", 12'(sd_command), 12'(PRE));
                        293: check("lit_ar293", 12'(sd_command), 12'(ARC));
                        299: check("lit_noovr299", 12'(refresh_overrun), 12'd0);
                        303: check("lit_pre303", 12'(sd_command), 12'(PRE));
                        392: check("lit_ovr392", 12'(refresh_overrun), 12'd0);
                        393: check("lit_ovr393", 12'(refresh_overrun), 12'd1);
                        404: check("lit_pre404", 12'(sd_command), 12'(PRE));
                        450: check("lit_ovr450", 12'(refresh_overrun), 12'd1);
                        default: ;
                    endcase
                end else if (seg == 2) begin
                    case (m_t)
                        21: check("lit_replay_pre21", 12'(sd_command), 12'(PRE));
                        43: check("lit_replay_ready43", 12'(ready), 12'd1);
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic drive();
        read_command  = 3'($urandom);
        read_address  = 12'($urandom);
        read_bank     = 2'($urandom);
        write_command = 3'($urandom);
        write_address = 12'($urandom);
        write_bank    = 2'($urandom);
        read_idle  = 1'b1;
        write_idle = 1'b1;
        if (seg == 0) begin
            if ((m_t >= 50 && m_t < 60) || (m_t >= 70 && m_t < 80) || (m_t >= 130 && m_t < 173))
                read_idle = 1'b0;
            if ((m_t >= 50 && m_t < 70) || (m_t >= 230 && m_t < 289) || (m_t >= 330 && m_t < 403))
                write_idle = 1'b0;
            if (m_t >= 50 && m_t < 60) begin
                read_command  = ACT;
                write_command = WRC;
            end
        end
    endtask

    task automatic run_to(input int target);
        int n = 0;
        while (m_t != target && n < 2000) begin
            @(posedge clk);
            #1;
            drive();
            n++;
        end
        if (m_t != target) begin
            vectors++;
            miscompares++;
            $display("FAIL run_to timeout: reached t=%0d, required t=%0d", m_t, target);
        end
    endtask

    task automatic hold_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            drive();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        seg = 0;
        drive();
        hold_reset(3);
        run_to(460);
        seg = 1;
        hold_reset(2);
        run_to(35);
        seg = 2;
        hold_reset(3);
        run_to(120);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
